pc14: RTL and testbench
=======================

Name: pc14

Overview:
- 14-bit program control unit for the 16-bit CPU core.
- Computes the next program-memory fetch address from the instruction word currently being executed.
- Covers sequential fetch, conditional jumps with H-register page extension, subroutine call/return on a 16-entry return stack, return-address store, and single-instruction repeat.
- Sits between the synchronous program memory and the instruction decoder.

Parameters:
- SDEPTH, 16, return-stack depth in entries (power of two).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- paddr  out  14  program memory fetch address (combinational from PC register and pdata)
- pdata  in  16  instruction word fetched from the previous paddr (1-cycle synchronous memory)
- rdata  in  14  register-file data, pushed by STRA
- flags  in  4  condition flags; flags[0] tied 1 by convention (always), flags[1] = V
- hv  in  1  H-prefix valid for the current instruction
- h6  in  6  H-prefix high address bits
- ce  in  1  clock enable; when 0 all state holds

Behaviour:
- State:
  - pc[13:0]: address of the instruction currently on pdata.
  - Return stack: SDEPTH×14, stack pointer sp.
  - Repeat counter rc[8:0].
- Reset (rst=1, takes priority over ce):
  - paddr = 0; pc <= 0; sp <= 0; rc <= 0.
  - The first post-reset pdata is mem[0].
- ce=0: paddr = pc; no register changes.
- ce=1: pc <= paddr every cycle. The default is paddr = pc+1, wrapping modulo 2^14.
- Decode on pdata[15:12], applied in the same cycle. There are no delay slots.
- 00xx CALL:
  - paddr = pdata[13:0].
  - Push pc+1: stack[sp] <= pc+1, sp <= sp+1.
- 0100 JMP/Jcc:
  - cond = flags[pdata[11:10]] XOR pdata[9]. pdata[8] is reserved.
  - Target = {hv ? h6 : pc[13:8], pdata[7:0]}.
  - If cond, paddr = target; else paddr = pc+1.
- 0101 RET: paddr = stack[sp-1]; sp <= sp-1.
- 0110 with pdata[11]=1 (REP):
  - paddr = pc+1; rc <= pdata[7:0]+1.
  - The next instruction executes pdata[7:0]+2 times in total.
- 0110 with pdata[11]=0 and pdata[10]=1 (STRA):
  - Push rdata: stack[sp] <= rdata, sp <= sp+1.
  - paddr = pc+1.
  - The write is visible to any RET executing at or after the next cycle.
- All other opcodes are NOP for this unit, including ALU ops and LDH; paddr = pc+1.
- Repeat:
  - While rc≠0 and the current instruction is not a flow-change (CALL, taken jump, RET), paddr = pc and rc <= rc-1.
  - A flow-change executed under repeat takes effect and clears rc.
- Stack:
  - Circular; overflow wraps and overwrites the oldest entry.
  - Underflow wraps sp and returns a stale entry. No error flag.
- hv/h6 affect only the jump target. LDH itself is executed by another unit, which drives hv/h6 alongside the following instruction.

Test Plan:
- Reset, then 4010 with flags=0001, pc=1 → paddr=0x0010; next cycle pc=0x0010.
- CALL 0111, CALL 0222, NOP, RET, NOP, RET → paddr sequence:
  - 0x0111, 0x0222, 0x0223.
  - RET to 0x0112, then 0x0113.
  - RET to 0x0011.
  - sp returns to 0.
- REP 6800 then NOP → NOP address fetched twice (paddr=pc held one cycle); rc=0 afterwards.
- Conditional jumps with flags[1]=0:
  - JV 4410 → pc+1.
  - JNV 4610 → page-relative target 0xXX10.
  - With hv=1, h6=1, JNV 4610 → paddr=0x0110.
- STRA 6400 with rdata=0x0333, NOP, RET 5000 → RET yields paddr=0x0333.
- ce=0 for 2 cycles mid-sequence → paddr=pc constant, no stack/rc change. rst asserted during repeat → paddr=0, rc=0, sp=0.

Source files
------------

// File: rtl/pc14_if.sv
// Program-fetch bus between pc14, program memory and the decoder side.
// master = the program control unit (drives the fetch address).
interface pc14_if;
    logic [13:0] paddr;
    logic [15:0] pdata;
    logic [13:0] rdata;
    logic [3:0]  flags;
    logic        hv;
    logic [5:0]  h6;
    logic        ce;

    modport master (output paddr, input pdata, rdata, flags, hv, h6, ce);
    modport slave  (input paddr, output pdata, rdata, flags, hv, h6, ce);
endinterface

// File: rtl/pc14.sv
// 14-bit program control: next fetch address from the executing instruction.
// paddr is combinational from state and pdata; ce=0 freezes all state.
module pc14 #(
    parameter int SDEPTH = 16
) (
    input  logic     clk,
    input  logic     rst,
    pc14_if.master   bus
);
    localparam int SPW = $clog2(SDEPTH);

    logic [13:0]    pc_q, pc_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic [8:0]     rc_q, rc_d;
    logic [13:0]    stack_q [SDEPTH];

    logic [13:0]    paddr_c;
    logic [13:0]    pc_inc;
    logic [13:0]    jmp_tgt;
    logic [SPW-1:0] sp_dec;
    logic [3:0]     op;
    logic           cond;
    logic           is_call, is_jmp, is_ret, is_rep, is_stra;
    logic           push_en;
    logic [13:0]    push_dat;

    assign bus.paddr = paddr_c;

    always_comb begin
        op       = bus.pdata[15:12];
        pc_inc   = pc_q + 14'd1;
        cond     = bus.flags[bus.pdata[11:10]] ^ bus.pdata[9];
        jmp_tgt  = {(bus.hv ? bus.h6 : pc_q[13:8]), bus.pdata[7:0]};
        sp_dec   = sp_q - SPW'(1);
        is_call  = (op[3:2] == 2'b00);
        is_jmp   = (op == 4'b0100) && cond;
        is_ret   = (op == 4'b0101);
        is_rep   = (op == 4'b0110) && bus.pdata[11];
        is_stra  = (op == 4'b0110) && !bus.pdata[11] && bus.pdata[10];

        paddr_c  = pc_q;
        pc_d     = pc_q;
        sp_d     = sp_q;
        rc_d     = rc_q;
        push_en  = 1'b0;
        push_dat = pc_inc;

        if (rst) begin
            paddr_c = 14'd0;
            pc_d    = 14'd0;
            sp_d    = '0;
            rc_d    = 9'd0;
        end else if (bus.ce) begin
            paddr_c = pc_inc;
            // Flow changes win over an active repeat and cancel it.
            if (is_call) begin
                paddr_c = bus.pdata[13:0];
                push_en = 1'b1;
                sp_d    = sp_q + SPW'(1);
                rc_d    = 9'd0;
            end else if (is_jmp) begin
                paddr_c = jmp_tgt;
                rc_d    = 9'd0;
            end else if (is_ret) begin
                paddr_c = stack_q[sp_dec];
                sp_d    = sp_dec;
                rc_d    = 9'd0;
            end else begin
                if (is_stra) begin
                    push_en  = 1'b1;
                    push_dat = bus.rdata;
                    sp_d     = sp_q + SPW'(1);
                end
                if (rc_q != 9'd0) begin
                    paddr_c = pc_q;
                    rc_d    = rc_q - 9'd1;
                end else if (is_rep) begin
                    rc_d = {1'b0, bus.pdata[7:0]} + 9'd1;
                end
            end
            pc_d = paddr_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= 14'd0;
            sp_q <= '0;
            rc_q <= 9'd0;
        end else begin
            pc_q <= pc_d;
            sp_q <= sp_d;
            rc_q <= rc_d;
        end
    end

    // Stack contents are not reset; underflow reads whatever was left there.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_q[sp_q] <= push_dat;
        end
    end
endmodule

// File: tb/tb_pc14.sv
module tb_pc14;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pc14_if bus ();

    pc14 #(.SDEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rst;
        logic        ce;
        logic [15:0] pdata;
        logic [3:0]  flags;
        logic        hv;
        logic [5:0]  h6;
        logic [13:0] rdata;
        logic [13:0] exp_paddr;
        logic [3:0]  exp_sp;
        logic [8:0]  exp_rc;
    } vec_t;

    typedef struct {
        logic [13:0] paddr;
        logic [3:0]  sp;
        logic [8:0]  rc;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   step  = 0;

    function automatic vec_t mk(input logic r, input logic c, input logic [15:0] pd,
                                input logic [3:0] fl, input logic h, input logic [5:0] hh,
                                input logic [13:0] rd, input logic [13:0] ep,
                                input logic [3:0] es, input logic [8:0] er);
        vec_t v;
        v.rst = r; v.ce = c; v.pdata = pd; v.flags = fl; v.hv = h; v.h6 = hh;
        v.rdata = rd; v.exp_paddr = ep; v.exp_sp = es; v.exp_rc = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %h want %h", name, step, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        rst       = v.rst;
        bus.ce    = v.ce;
        bus.pdata = v.pdata;
        bus.flags = v.flags;
        bus.hv    = v.hv;
        bus.h6    = v.h6;
        bus.rdata = v.rdata;
        sb.push_back('{paddr: v.exp_paddr, sp: v.exp_sp, rc: v.exp_rc});
        #1;
        e = sb.pop_front();
        check("paddr", {2'b00, bus.paddr}, {2'b00, e.paddr});
        @(posedge clk);
        #1;
        check("sp", {12'd0, dut.sp_q}, {12'd0, e.sp});
        check("rc", {7'd0, dut.rc_q}, {7'd0, e.rc});
        step++;
    endtask

    initial begin
        logic [13:0] m_pc;

        rst = 1'b1; bus.ce = 1'b1; bus.pdata = 16'h7000; bus.flags = 4'b0001;
        bus.hv = 1'b0; bus.h6 = 6'd0; bus.rdata = 14'd0;

        //          rst ce pdata     flags  hv h6    rdata     paddr     sp rc
        tbl.push_back(mk(1, 1, 16'h7000, 4'h1, 0, 6'h00, 14'h000, 14'h000, 0, 9'h00));
        tbl.push_back(mk(0, 1, 16'h7000, 4'h1, 0, 6'h00, 14'h000, 14'h001, 0, 9'h00));
        tbl.push_back(mk(0, 1, 16'h4010, 4'h1, 0, 6'h00, 14'h000, 14'h010, 0, 9'h00));
        tbl.push_back(mk(0, 1, 16'h0111, 4'h1, 0, 6'h00, 14'h000, 14'h111, 1, 9'h00));
        tbl.push_back(mk(0, 1, 16'h0222, 4'h1, 0, 6'h00, 14'h000, 14'h222, 2, 9'h00));
        tbl.push_back(mk(0, 1, 16'h7000, 4'h1, 0, 6'h00, 14'h000, 14'h223, 2, 9'h00));
        tbl.push_back(mk(0, 1, 16'h5000, 4'h1, 0, 6'h00, 14'h000, 14'h112, 1, 9'h00));
        tbl.push_back(mk(0, 1, 16'h7000, 4'h1, 0, 6'h00, 14'h000, 14'h113, 1, 9'h00));
        tbl.push_back(mk(0, 1, 16'h5000, 4'h1, 0, 6'h00, 14'h000, 14'h011, 0, 9'h00));
        tbl.push_back(mk(0, 1, 16'h6800, 4'h1, 0, 6'h00, 14'h000, 14'h012, 0, 9'h01));
        tbl.push_back(mk(0, 1, 16'h7000, 4'h1, 0, 6'h00, 14'h000, 14'h012, 0, 9'h00));
        tbl.push_back(mk(0, 1, 16'hF123, 4'h1, 0, 6'h00, 14'h000, 14'h013, 0, 9'h00));
        tbl.push_back(mk(0, 1, 16'h4410, 4'h1, 0, 6'h00, 14'h000, 14'h014, 0, 9'h00));
        tbl.push_back(mk(0, 1, 16'h4610, 4'h1, 0, 6'h00, 14'h000, 14'h010, 0, 9'h00));
        tbl.push_back(mk(0, 1, 16'h4610, 4'h1, 1, 6'h01, 14'h000, 14'h110, 0, 9'h00));
        tbl.push_back(mk(0, 1, 16'h4410, 4'h1, 1, 6'h3F, 14'h000, 14'h111, 0, 9'h00));
        tbl.push_back(mk(0, 1, 16'h4C20, 4'h9, 0, 6'h00, 14'h000, 14'h120, 0, 9'h00));
        tbl.push_back(mk(0, 1, 16'h6400, 4'h1, 0, 6'h00, 14'h333, 14'h121, 1, 9'h00));
        tbl.push_back(mk(0, 1, 16'h7000, 4'h1, 0, 6'h00, 14'h000, 14'h122, 1, 9'h00));
        tbl.push_back(mk(0, 1, 16'h5000, 4'h1, 0, 6'h00, 14'h000, 14'h333, 0, 9'h00));
        tbl.push_back(mk(0, 1, 16'h6802, 4'h1, 0, 6'h00, 14'h000, 14'h334, 0, 9'h03));
        tbl.push_back(mk(0, 0, 16'h7000, 4'h1, 0, 6'h00, 14'h000, 14'h334, 0, 9'h03));
        tbl.push_back(mk(0, 0, 16'h0ABC, 4'h1, 0, 6'h00, 14'h000, 14'h334, 0, 9'h03));
        tbl.push_back(mk(0, 1, 16'h7000, 4'h1, 0, 6'h00, 14'h000, 14'h334, 0, 9'h02));
        tbl.push_back(mk(0, 1, 16'h7000, 4'h1, 0, 6'h00, 14'h000, 14'h334, 0, 9'h01));
        tbl.push_back(mk(0, 1, 16'h7000, 4'h1, 0, 6'h00, 14'h000, 14'h334, 0, 9'h00));
        tbl.push_back(mk(0, 1, 16'h7000, 4'h1, 0, 6'h00, 14'h000, 14'h335, 0, 9'h00));
        tbl.push_back(mk(0, 1, 16'h6805, 4'h1, 0, 6'h00, 14'h000, 14'h336, 0, 9'h06));
        tbl.push_back(mk(0, 1, 16'h7000, 4'h1, 0, 6'h00, 14'h000, 14'h336, 0, 9'h05));
        tbl.push_back(mk(0, 1, 16'h0200, 4'h1, 0, 6'h00, 14'h000, 14'h200, 1, 9'h00));
        tbl.push_back(mk(0, 1, 16'h7000, 4'h1, 0, 6'h00, 14'h000, 14'h201, 1, 9'h00));
        tbl.push_back(mk(0, 1, 16'h6810, 4'h1, 0, 6'h00, 14'h000, 14'h202, 1, 9'h11));
        tbl.push_back(mk(0, 1, 16'h7000, 4'h1, 0, 6'h00, 14'h000, 14'h202, 1, 9'h10));
        tbl.push_back(mk(1, 0, 16'h7000, 4'h1, 0, 6'h00, 14'h000, 14'h000, 0, 9'h00));
        tbl.push_back(mk(0, 1, 16'h6000, 4'h1, 0, 6'h00, 14'h000, 14'h001, 0, 9'h00));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // Overflow: 17 pushes wrap sp back to 1, entry 0 holds the 17th value.
        m_pc = 14'h001;
        for (int i = 0; i < 17; i++) begin
            apply(mk(0, 1, 16'h6400, 4'h1, 0, 6'h00, 14'h100 + 14'(i),
                     m_pc + 14'd1, 4'(i + 1), 9'h00));
            m_pc = m_pc + 14'd1;
        end
        apply(mk(0, 1, 16'h5000, 4'h1, 0, 6'h00, 14'h000, 14'h110, 4'd0, 9'h00));
        // Pop through sp=0 wraps to the top entry.
        apply(mk(0, 1, 16'h5000, 4'h1, 0, 6'h00, 14'h000, 14'h10F, 4'd15, 9'h00));
        apply(mk(0, 1, 16'h5000, 4'h1, 0, 6'h00, 14'h000, 14'h10E, 4'd14, 9'h00));

        // Jump to the last address via H-prefix, then sequential fetch wraps to 0.
        apply(mk(0, 1, 16'h40FF, 4'h1, 1, 6'h3F, 14'h000, 14'h3FFF, 4'd14, 9'h00));
        apply(mk(0, 1, 16'h7000, 4'h1, 0, 6'h00, 14'h000, 14'h0000, 4'd14, 9'h00));
        apply(mk(0, 1, 16'h7000, 4'h1, 0, 6'h00, 14'h000, 14'h0001, 4'd14, 9'h00));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
